// File: rtl/mem_access_unit.sv
// +------------------------------------------------------------------------------+
// | mem_access_unit: load/store lane packing, load extension, bus handshake FSM. |
// | Optional bus timeout when MAU_TIMEOUT_EN is defined.  Rev 1.0                |
// +------------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic        done_q, done_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        timeout_hit;
  logic        req_misaligned;
  logic        req_is_store;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

`ifdef MAU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Counter is zero whenever outside BUS, so it starts from zero on entry.
  always_comb begin
    tmo_cnt_d = 8'd0;
    if (state_q == BUS && !bus_ack) tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= 8'd0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = (tmo_cnt_q == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // Request decode from the live CPU inputs (valid only in IDLE).
  always_comb begin
    req_is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    case (op)
      OP_LW, OP_SW:         req_misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_misaligned = addr[0];
      default:              req_misaligned = 1'b0;
    endcase
    case (op)
      OP_SH:   req_be = addr[1] ? 4'b1100 : 4'b0011;
      OP_SB:   req_be = 4'b0001 << addr[1:0];
      default: req_be = 4'b1111;
    endcase
    case (op)
      OP_SH:   req_wdata = {2{wdata[15:0]}};
      OP_SB:   req_wdata = {4{wdata[7:0]}};
      default: req_wdata = wdata;
    endcase
  end

  // Load lane extraction and extension from the registered op/lane.
  always_comb begin
    ld_byte = 8'(bus_rdata >> {lane_q, 3'b000});
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      OP_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_value = {16'h0000, ld_half};
      OP_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_value = {24'h000000, ld_byte};
      default: ld_value = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    done_d      = 1'b0;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    rdata_d     = rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d     = RESP;
            done_d      = 1'b1;
            align_err_d = 1'b1;
          end else begin
            state_d     = BUS;
            op_d        = op;
            lane_d      = addr[1:0];
            bus_req_d   = 1'b1;
            bus_we_d    = req_is_store;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_wdata;
          end
        end
      end
      BUS: begin
        // An ack in the limit cycle takes priority over the timeout.
        if (bus_ack) begin
          state_d   = RESP;
          done_d    = 1'b1;
          bus_req_d = 1'b0;
          if (!bus_we_q) rdata_d = ld_value;
        end else if (timeout_hit) begin
          state_d   = RESP;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          rdata_d   = 32'h0000_0000;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      done_q      <= 1'b0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      done_q      <= done_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign stall     = (state_q == BUS) || ((state_q == IDLE) && req_valid);
  assign done      = done_q;
  assign align_err = align_err_q;
  assign bus_err   = bus_err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses
// compared against an arithmetic reference model.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall, done, align_err, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    int          done_cyc;
    int          ndone;
    int          stall_cnt;
    int          req_cnt;
    int          stray;
    int          unstable;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rd;
    logic [3:0]  be;
    logic        we;
    logic        al;
    logic        berr;
  } obs_t;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .align_err(align_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Reference model: access size, load result, byte enables, write data.
  function automatic int unsigned size_of(input logic [2:0] o);
    case (o)
      3'd0, 3'd5:       return 4;
      3'd1, 3'd2, 3'd6: return 2;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] w);
    longint v;
    int unsigned off = a % 4;
    case (o)
      3'd1, 3'd2: begin
        v = (w >> (8 * (off / 2 * 2))) & 32'hFFFF;
        if (o == 3'd1 && v >= 32768) v -= 65536;
      end
      3'd3, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (o == 3'd3 && v >= 128) v -= 256;
      end
      default: v = w;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] o, input logic [31:0] a);
    if (o == 3'd6) return 4'(3 << (a & 2));
    if (o == 3'd7) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] o, input logic [31:0] w);
    if (o == 3'd6) return (w & 32'hFFFF) * 32'h0001_0001;
    if (o == 3'd7) return (w & 32'hFF) * 32'h0101_0101;
    return w;
  endfunction

  // Drives one request and acts as the bus; ack_at is the cycle of bus_ack
  // (negative = never). Cycle 0 is the request cycle. Bounded to 40 cycles.
  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                        input int ack_at, input logic [31:0] word, input bit spur,
                        output obs_t ob);
    ob = '{default: 0};
    ob.done_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      req_valid = (cyc == 0);
      op = o; addr = a; wdata = w;
      bus_ack = (cyc == ack_at) || (spur && (cyc == 0 || (ack_at > 0 && cyc > ack_at)));
      bus_rdata = (cyc == ack_at) ? word : $urandom;
      #1;
      if (stall) ob.stall_cnt++;
      if ((align_err || bus_err) && !done) ob.stray++;
      if (bus_req) begin
        if (ob.req_cnt == 0) begin
          ob.baddr = bus_addr; ob.be = bus_be; ob.we = bus_we; ob.bwdata = bus_wdata;
        end else if ({bus_addr, bus_be, bus_we, bus_wdata} !== {ob.baddr, ob.be, ob.we, ob.bwdata}) begin
          ob.unstable++;
        end
        ob.req_cnt++;
      end
      if (done) begin
        if (ob.ndone == 0) begin
          ob.done_cyc = cyc; ob.al = align_err; ob.berr = bus_err; ob.rd = rdata;
        end
        ob.ndone++;
      end
      if (ob.ndone > 0 && cyc >= ob.done_cyc + 2) break;
    end
    req_valid = 1'b0;
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall, done, rdata, align_err, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h bus_req=%b bus_addr=%h be=%h done=%b, want all zero",
               rdata, bus_req, bus_addr, bus_be, done);
    end
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_load_byte();
    obs_t ob;
    access(3'd3, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 1'b0, ob);
    checks++;
    if ({ob.baddr, ob.be, ob.we} !== {32'h0000_1000, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL lb_bus: got addr=%h be=%h we=%b, want 00001000 f 0", ob.baddr, ob.be, ob.we);
    end
    checks++;
    if (ob.done_cyc != 2 || ob.ndone != 1) begin
      errors++;
      $display("FAIL lb_done: got cycle=%0d pulses=%0d, want cycle 2 pulses 1", ob.done_cyc, ob.ndone);
    end
    checks++;
    if (ob.rd !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_rdata: got %h, want ffffff80", ob.rd);
    end
    access(3'd4, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 1'b0, ob);
    checks++;
    if (ob.rd !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_rdata: got %h, want 00000080", ob.rd);
    end
    model_rdata = 32'h0000_0080;
  endtask

  task automatic test_store_half();
    obs_t ob;
    access(3'd6, 32'h0000_2002, 32'hABCD_5678, 2, 32'hDEAD_BEEF, 1'b0, ob);
    checks++;
    if ({ob.we, ob.be, ob.bwdata, ob.baddr} !== {1'b1, 4'b1100, 32'h5678_5678, 32'h0000_2000}) begin
      errors++;
      $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h, want 1 1100 56785678 00002000",
               ob.we, ob.be, ob.bwdata, ob.baddr);
    end
    checks++;
    if (ob.stall_cnt != 3 || ob.done_cyc != 3) begin
      errors++;
      $display("FAIL sh_timing: got stall=%0d done_cycle=%0d, want 3 and 3", ob.stall_cnt, ob.done_cyc);
    end
    checks++;
    if (ob.rd !== model_rdata) begin
      errors++;
      $display("FAIL sh_rdata_hold: got %h, want %h", ob.rd, model_rdata);
    end
  endtask

  task automatic test_misaligned();
    obs_t ob;
    access(3'd0, 32'h0000_3001, 32'h0, 1, 32'h1111_2222, 1'b1, ob);
    checks++;
    if (ob.done_cyc != 1 || ob.ndone != 1 || ob.al !== 1'b1 || ob.req_cnt != 0) begin
      errors++;
      $display("FAIL lw_misaligned: got done_cycle=%0d pulses=%0d align=%b bus_req_cycles=%0d, want 1 1 1 0",
               ob.done_cyc, ob.ndone, ob.al, ob.req_cnt);
    end
    checks++;
    if (ob.rd !== model_rdata) begin
      errors++;
      $display("FAIL misaligned_rdata: got %h, want %h", ob.rd, model_rdata);
    end
  endtask

  task automatic test_delayed_half();
    obs_t ob;
    access(3'd1, 32'h0000_4002, 32'h0, 5, 32'h9ABC_0000, 1'b1, ob);
    checks++;
    if (ob.stall_cnt != 6 || ob.ndone != 1 || ob.done_cyc != 6) begin
      errors++;
      $display("FAIL lh_delay: got stall=%0d pulses=%0d done_cycle=%0d, want 6 1 6",
               ob.stall_cnt, ob.ndone, ob.done_cyc);
    end
    checks++;
    if (ob.rd !== 32'hFFFF_9ABC) begin
      errors++;
      $display("FAIL lh_rdata: got %h, want ffff9abc", ob.rd);
    end
    model_rdata = 32'hFFFF_9ABC;
  endtask

  task automatic test_reset_mid_bus();
    obs_t ob;
    int dones = 0;
    @(negedge clk);
    req_valid = 1'b1; op = 3'd5; addr = 32'h0000_5000; wdata = 32'h1234_5678; bus_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL sw_bus_req: got %b, want 1", bus_req);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({stall, done, rdata, align_err, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL midbus_reset: got bus_req=%b done=%b rdata=%h addr=%h, want all zero",
               bus_req, done, rdata, bus_addr);
    end
    model_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midbus_no_done: got %0d done pulses, want 0", dones);
    end
    access(3'd0, 32'h0000_5004, 32'h0, 2, 32'hCAFE_F00D, 1'b0, ob);
    checks++;
    if (ob.done_cyc != 3 || ob.rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lw_after_reset: got done_cycle=%0d rdata=%h, want 3 cafef00d", ob.done_cyc, ob.rd);
    end
    model_rdata = 32'hCAFE_F00D;
  endtask

`ifdef MAU_TIMEOUT_EN
  task automatic test_timeout();
    obs_t ob;
    access(3'd0, 32'h0000_6000, 32'h0, -1, 32'h0, 1'b0, ob);
    checks++;
    if (ob.req_cnt != 4 || ob.done_cyc != 5 || ob.berr !== 1'b1 || ob.rd !== 32'h0) begin
      errors++;
      $display("FAIL timeout_abort: got bus_req_cycles=%0d done_cycle=%0d bus_err=%b rdata=%h, want 4 5 1 0",
               ob.req_cnt, ob.done_cyc, ob.berr, ob.rd);
    end
    model_rdata = 32'h0;
    access(3'd0, 32'h0000_6004, 32'h0, 4, 32'h0BAD_CAFE, 1'b0, ob);
    checks++;
    if (ob.done_cyc != 5 || ob.berr !== 1'b0 || ob.rd !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL timeout_ack_wins: got done_cycle=%0d bus_err=%b rdata=%h, want 5 0 0badcafe",
               ob.done_cyc, ob.berr, ob.rd);
    end
    model_rdata = 32'h0BAD_CAFE;
  endtask
`endif

  task automatic test_random();
    obs_t ob;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  o    = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom;
      logic [31:0] w    = $urandom;
      logic [31:0] word = $urandom;
      int          lat  = $urandom_range(1, 4);
      int unsigned sz   = size_of(o);
      bit          is_ld = (o < 3'd5);
      bit          mis;
      logic [31:0] exp_rd;
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      mis = (a % sz) != 0;
      access(o, a, w, lat, word, 1'($urandom_range(0, 1)), ob);
      exp_rd = (!mis && is_ld) ? ld_model(o, a, word) : model_rdata;
      checks++;
      if (ob.ndone != 1 || ob.done_cyc != (mis ? 1 : lat + 1) || ob.stray != 0 || ob.unstable != 0) begin
        errors++;
        $display("FAIL rand_handshake[%0d] op=%0d addr=%h: got done_cycle=%0d pulses=%0d stray=%0d unstable=%0d, want done_cycle=%0d pulses=1",
                 n, o, a, ob.done_cyc, ob.ndone, ob.stray, ob.unstable, mis ? 1 : lat + 1);
      end
      checks++;
      if (ob.req_cnt != (mis ? 0 : lat) || ob.stall_cnt != (mis ? 1 : lat + 1) ||
          ob.al !== mis || ob.berr !== 1'b0) begin
        errors++;
        $display("FAIL rand_flags[%0d] op=%0d addr=%h: got req=%0d stall=%0d align=%b berr=%b, want req=%0d stall=%0d align=%b berr=0",
                 n, o, a, ob.req_cnt, ob.stall_cnt, ob.al, ob.berr, mis ? 0 : lat, mis ? 1 : lat + 1, mis);
      end
      checks++;
      if (ob.rd !== exp_rd) begin
        errors++;
        $display("FAIL rand_rdata[%0d] op=%0d addr=%h word=%h: got %h, want %h", n, o, a, word, ob.rd, exp_rd);
      end
      if (!mis) begin
        checks++;
        if (ob.baddr !== (a - (a % 4)) || ob.be !== be_model(o, a) || ob.we !== !is_ld ||
            (!is_ld && ob.bwdata !== wd_model(o, w))) begin
          errors++;
          $display("FAIL rand_bus[%0d] op=%0d addr=%h: got addr=%h be=%h we=%b wdata=%h, want addr=%h be=%h we=%b wdata=%h",
                   n, o, a, ob.baddr, ob.be, ob.we, ob.bwdata, a - (a % 4), be_model(o, a), !is_ld, wd_model(o, w));
        end
      end
      model_rdata = exp_rd;
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_delayed_half();
    test_reset_mid_bus();
`ifdef MAU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
